alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 130 +++++++++++++
 tb/tb_alu_arbiter.sv | 505 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared combinational ALU.
// One operation in flight at a time: accept, issue to the ALU, hold the response until taken.
module alu_arbiter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [3:0]   req0_ctl,
  input  logic [3:0]   req1_ctl,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp0_valid,
  output logic         rsp1_valid,
  input  logic         rsp0_ready,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp0_out,
  output logic [W-1:0] rsp1_out,
  output logic         rsp0_zero,
  output logic         rsp1_zero,
  output logic [3:0]   alu_ctl,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_out,
  input  logic         alu_zero,
  output logic [15:0]  ops_done
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e         state_q, state_d;
  logic           grant_q, grant_d;
  logic           last_q, last_d;
  logic [3:0]     ctl_q, ctl_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   res_q, res_d;
  logic           zero_q, zero_d;
  logic [15:0]    ops_q, ops_d;
  logic           any_valid;
  logic           pick;

  assign any_valid = req0_valid | req1_valid;
  // On a tie the requester not served last wins; otherwise whichever is valid.
  assign pick      = (req0_valid && req1_valid) ? ~last_q : ~req0_valid;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    ctl_d      = ctl_q;
    a_d        = a_q;
    b_d        = b_q;
    res_d      = res_q;
    zero_d     = zero_q;
    ops_d      = ops_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_valid) begin
          grant_d    = pick;
          ctl_d      = pick ? req1_ctl : req0_ctl;
          a_d        = pick ? req1_a : req0_a;
          b_d        = pick ? req1_b : req0_b;
          // Ready is masked during reset so nothing appears accepted while rst_n is low.
          req0_ready = rst_n & ~pick;
          req1_ready = rst_n & pick;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        res_d   = alu_out;
        zero_d  = alu_zero;
        state_d = StResp;
      end
      StResp: begin
        rsp0_valid = ~grant_q;
        rsp1_valid = grant_q;
        if (grant_q ? rsp1_ready : rsp0_ready) begin
          state_d = StIdle;
          ops_d   = ops_q + 16'd1;
          last_d  = grant_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      ctl_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      ctl_q   <= ctl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ops_q   <= ops_d;
    end
  end

  assign alu_ctl   = ctl_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign rsp0_out  = res_q;
  assign rsp1_out  = res_q;
  assign rsp0_zero = zero_q;
  assign rsp1_zero = zero_q;
  assign ops_done  = ops_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU on the shared port, per-requester expected-result queues.
module tb_alu_arbiter;
  localparam int unsigned W = 32;

  logic         clk, rst_n;
  logic         req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0]   req0_ctl, req1_ctl, alu_ctl;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [W-1:0] rsp0_out, rsp1_out, alu_a, alu_b, alu_out;
  logic         rsp0_zero, rsp1_zero, alu_zero;
  logic [15:0]  ops_done;

  logic [W:0]   exp0_q[$];
  logic [W:0]   exp1_q[$];
  logic [15:0]  ops_model;
  int           errors = 0;
  int           checks = 0;

  alu_arbiter #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_ctl(req0_ctl), .req1_ctl(req1_ctl),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp0_out(rsp0_out), .rsp1_out(rsp1_out),
    .rsp0_zero(rsp0_zero), .rsp1_zero(rsp1_zero),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .ops_done(ops_done)
  );

  function automatic logic [W:0] alu_model(input logic [3:0] c, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W-1:0] r;
    case (c)
      4'd0:    r = a & b;
      4'd1:    r = a | b;
      4'd2:    r = a + b;
      4'd6:    r = a - b;
      4'd7:    r = ($signed(a) < $signed(b)) ? W'(1) : '0;
      4'd12:   r = ~(a | b);
      default: r = '0;
    endcase
    return {(r == '0), r};
  endfunction

  assign {alu_zero, alu_out} = alu_model(alu_ctl, alu_a, alu_b);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic drive_req(input int idx, input logic [3:0] c, input logic [W-1:0] a,
                           input logic [W-1:0] b);
    if (idx == 0) begin
      req0_valid = 1'b1; req0_ctl = c; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_ctl = c; req1_a = a; req1_b = b;
    end
  endtask

  task automatic drop_req(input int idx);
    if (idx == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  task automatic push_exp(input int idx, input logic [3:0] c, input logic [W-1:0] a,
                          input logic [W-1:0] b);
    if (idx == 0) exp0_q.push_back(alu_model(c, a, b));
    else exp1_q.push_back(alu_model(c, a, b));
  endtask

  task automatic pop_exp(input int idx, output logic [W:0] e);
    e = 'x;
    if (idx == 0 && exp0_q.size() > 0) e = exp0_q.pop_front();
    if (idx == 1 && exp1_q.size() > 0) e = exp1_q.pop_front();
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input int idx, input logic [3:0] c, input logic [W-1:0] a,
                      input logic [W-1:0] b, output bit got);
    drive_req(idx, c, a, b);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((idx == 0) ? req0_ready : req1_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (got) begin
      push_exp(idx, c, a, b);
      @(posedge clk);
      @(negedge clk);
    end
    drop_req(idx);
  endtask

  // Called at a negedge; waits for the response and optionally takes it.
  task automatic take_rsp(input int idx, input bit ack, output logic [W:0] obs,
                          output int waited, output bit got);
    waited = 0;
    got    = 1'b0;
    obs    = 'x;
    for (int i = 0; i < 20; i++) begin
      if ((idx == 0) ? rsp0_valid : rsp1_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      waited++;
    end
    if (got) begin
      obs = (idx == 0) ? {rsp0_zero, rsp0_out} : {rsp1_zero, rsp1_out};
      if (ack) begin
        if (idx == 0) rsp0_ready = 1'b1;
        else rsp1_ready = 1'b1;
        @(posedge clk);
        ops_model = ops_model + 16'd1;
        @(negedge clk);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
      end
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    ops_model = '0;
    exp0_q.delete();
    exp1_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_req(0, 4'd2, 32'd5, 32'd7);
    #3;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready);
    end
    checks++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || ops_done !== 16'd0) begin
      errors++;
      $display("FAIL reset_rsp: got v=%b%b ops=%h expected v=00 ops=0", rsp0_valid,
               rsp1_valid, ops_done);
    end
    checks++;
    if ({alu_ctl, alu_a, alu_b, rsp0_out, rsp0_zero} !== '0) begin
      errors++;
      $display("FAIL reset_regs: got ctl=%h a=%h b=%h out=%h z=%b expected all 0", alu_ctl,
               alu_a, alu_b, rsp0_out, rsp0_zero);
    end
    drop_req(0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_op();
    logic [W:0] obs, e;
    int waited;
    bit got;
    @(negedge clk);
    drive_req(0, 4'd2, 32'd5, 32'd7);
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_ready: got %b%b expected 10", req0_ready, req1_ready);
    end
    push_exp(0, 4'd2, 32'd5, 32'd7);
    @(posedge clk);
    @(negedge clk);
    drop_req(0);
    take_rsp(0, 1'b1, obs, waited, got);
    pop_exp(0, e);
    checks++;
    if (!got || waited != 1) begin
      errors++;
      $display("FAIL single_latency: got valid=%b wait=%0d expected valid=1 wait=1", got, waited);
    end
    checks++;
    if (obs !== e || obs !== {1'b0, 32'd12}) begin
      errors++;
      $display("FAIL single_result: got %h expected %h", obs, {1'b0, 32'd12});
    end
    checks++;
    if (ops_done !== 16'd1) begin
      errors++;
      $display("FAIL single_ops: got %0d expected 1", ops_done);
    end
  endtask

  task automatic test_tie();
    logic [W:0] obs, e;
    int waited, g, want;
    bit got;
    reset_pulse();
    drive_req(0, 4'd6, 32'd3, 32'd3);
    drive_req(1, 4'd1, 32'hF0, 32'h0F);
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL tie_first: got %b%b expected 10", req0_ready, req1_ready);
    end
    push_exp(0, 4'd6, 32'd3, 32'd3);
    @(posedge clk);
    @(negedge clk);
    drop_req(0);
    take_rsp(0, 1'b1, obs, waited, got);
    pop_exp(0, e);
    checks++;
    if (!got || obs !== e || obs !== {1'b1, 32'd0}) begin
      errors++;
      $display("FAIL tie_rsp0: got %h expected %h", obs, {1'b1, 32'd0});
    end
    #1;
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++;
      $display("FAIL tie_second: got %b%b expected 01", req0_ready, req1_ready);
    end
    push_exp(1, 4'd1, 32'hF0, 32'h0F);
    @(posedge clk);
    @(negedge clk);
    drop_req(1);
    take_rsp(1, 1'b1, obs, waited, got);
    pop_exp(1, e);
    checks++;
    if (!got || obs !== e || obs !== {1'b0, 32'hFF}) begin
      errors++;
      $display("FAIL tie_rsp1: got %h expected %h", obs, {1'b0, 32'hFF});
    end
    // Sustained tie: grants alternate starting with requester 0.
    drive_req(0, 4'd0, 32'hFF, 32'h3C);
    drive_req(1, 4'd12, 32'h0, 32'h0);
    want = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      g = (req0_ready && !req1_ready) ? 0 : (req1_ready && !req0_ready) ? 1 : -1;
      checks++;
      if (g != want) begin
        errors++;
        $display("FAIL tie_rr%0d: got grant %0d expected %0d", k, g, want);
      end
      if (g < 0) break;
      if (g == 0) push_exp(0, 4'd0, 32'hFF, 32'h3C);
      else push_exp(1, 4'd12, 32'h0, 32'h0);
      @(posedge clk);
      @(negedge clk);
      take_rsp(g, 1'b1, obs, waited, got);
      pop_exp(g, e);
      checks++;
      if (!got || obs !== e) begin
        errors++;
        $display("FAIL tie_rr_rsp%0d: got %h expected %h", k, obs, e);
      end
      want = 1 - want;
    end
    drop_req(0);
    drop_req(1);
    checks++;
    if (ops_done !== ops_model) begin
      errors++;
      $display("FAIL tie_ops: got %0d expected %0d", ops_done, ops_model);
    end
  endtask

  task automatic test_back_to_back();
    logic [W:0] e;
    int t0, t1, cyc;
    t0 = -1;
    t1 = -1;
    @(negedge clk);
    rsp0_ready = 1'b1;
    drive_req(0, 4'd6, 32'h100, 32'h1);
    for (cyc = 0; cyc < 12; cyc++) begin
      #1;
      if (rsp0_valid) begin
        pop_exp(0, e);
        checks++;
        if ({rsp0_zero, rsp0_out} !== e) begin
          errors++;
          $display("FAIL b2b_rsp: got %h expected %h", {rsp0_zero, rsp0_out}, e);
        end
        ops_model = ops_model + 16'd1;
      end
      if (req0_ready) begin
        push_exp(0, 4'd6, 32'h100, 32'h1);
        if (t0 < 0) t0 = cyc;
        else if (t1 < 0) t1 = cyc;
      end
      if (cyc < 11) @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    drop_req(0);
    for (int i = 0; i < 6; i++) begin
      #1;
      if (rsp0_valid) begin
        pop_exp(0, e);
        checks++;
        if ({rsp0_zero, rsp0_out} !== e) begin
          errors++;
          $display("FAIL b2b_drain: got %h expected %h", {rsp0_zero, rsp0_out}, e);
        end
        ops_model = ops_model + 16'd1;
      end
      @(negedge clk);
    end
    rsp0_ready = 1'b0;
    checks++;
    if (t0 < 0 || t1 - t0 != 3) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d expected 3", t1 - t0);
    end
    checks++;
    if (exp0_q.size() != 0 || ops_done !== ops_model) begin
      errors++;
      $display("FAIL b2b_ops: got pend=%0d ops=%0d expected pend=0 ops=%0d", exp0_q.size(),
               ops_done, ops_model);
    end
  endtask

  task automatic test_backpressure();
    logic [W:0] obs, e;
    int waited, bad;
    bit got;
    @(negedge clk);
    send(1, 4'd2, 32'h100, 32'h23, got);
    drive_req(0, 4'd1, 32'hA, 32'h5);
    take_rsp(1, 1'b0, obs, waited, got);
    pop_exp(1, e);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (rsp1_valid !== 1'b1 || {rsp1_zero, rsp1_out} !== e || req0_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (!got || bad != 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d bad cycles expected 0 (out %h want %h)", bad, obs, e);
    end
    rsp1_ready = 1'b1;
    @(posedge clk);
    ops_model = ops_model + 16'd1;
    @(negedge clk);
    rsp1_ready = 1'b0;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_resume: got %b expected 1", req0_ready);
    end
    push_exp(0, 4'd1, 32'hA, 32'h5);
    @(posedge clk);
    @(negedge clk);
    drop_req(0);
    take_rsp(0, 1'b1, obs, waited, got);
    pop_exp(0, e);
    checks++;
    if (!got || obs !== e || obs !== {1'b0, 32'hF}) begin
      errors++;
      $display("FAIL bp_rsp0: got %h expected %h", obs, {1'b0, 32'hF});
    end
  endtask

  task automatic test_passthrough();
    logic [W:0] obs, e;
    int waited;
    bit got;
    @(negedge clk);
    send(0, 4'd7, 32'h80000000, 32'd1, got);
    take_rsp(0, 1'b1, obs, waited, got);
    pop_exp(0, e);
    checks++;
    if (!got || obs !== e || obs !== {1'b0, 32'd1}) begin
      errors++;
      $display("FAIL slt: got %h expected %h", obs, {1'b0, 32'd1});
    end
    send(1, 4'd15, 32'h1234, 32'h5678, got);
    take_rsp(1, 1'b1, obs, waited, got);
    pop_exp(1, e);
    checks++;
    if (!got || obs !== e || obs !== {1'b1, 32'd0}) begin
      errors++;
      $display("FAIL undef_ctl: got %h expected %h", obs, {1'b1, 32'd0});
    end
  endtask

  task automatic test_reset_mid_resp();
    logic [W:0] obs, e;
    int waited;
    bit got;
    @(negedge clk);
    send(0, 4'd2, 32'd1, 32'd1, got);
    take_rsp(0, 1'b0, obs, waited, got);
    #2;
    rst_n = 1'b0;
    ops_model = '0;
    exp0_q.delete();
    #1;
    checks++;
    if (!got || rsp0_valid !== 1'b0 || ops_done !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid: got seen=%b v=%b ops=%0d expected seen=1 v=0 ops=0", got,
               rsp0_valid, ops_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_req(0, 4'd2, 32'd9, 32'd1);
    drive_req(1, 4'd6, 32'd9, 32'd1);
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_tie: got %b%b expected 10", req0_ready, req1_ready);
    end
    push_exp(0, 4'd2, 32'd9, 32'd1);
    @(posedge clk);
    @(negedge clk);
    drop_req(0);
    take_rsp(0, 1'b1, obs, waited, got);
    pop_exp(0, e);
    checks++;
    if (!got || obs !== e || obs !== {1'b0, 32'd10}) begin
      errors++;
      $display("FAIL rst_rsp0: got %h expected %h", obs, {1'b0, 32'd10});
    end
    drop_req(1);
  endtask

  task automatic test_wrap();
    logic [W:0] obs;
    int waited;
    bit got;
    @(negedge clk);
    force dut.ops_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.ops_q;
    ops_model = 16'hFFFF;
    #1;
    checks++;
    if (ops_done !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_preset: got %h expected ffff", ops_done);
    end
    @(negedge clk);
    send(0, 4'd2, 32'd2, 32'd2, got);
    take_rsp(0, 1'b1, obs, waited, got);
    exp0_q.delete();
    checks++;
    if (!got || ops_done !== 16'd0 || ops_model !== 16'd0) begin
      errors++;
      $display("FAIL wrap_zero: got %h expected 0000", ops_done);
    end
    send(1, 4'd2, 32'd2, 32'd2, got);
    take_rsp(1, 1'b1, obs, waited, got);
    exp1_q.delete();
    checks++;
    if (!got || ops_done !== 16'd1) begin
      errors++;
      $display("FAIL wrap_one: got %h expected 0001", ops_done);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_ctl = '0; req1_ctl = '0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    ops_model = '0;
    test_reset();
    test_single_op();
    test_tie();
    test_back_to_back();
    test_backpressure();
    test_passthrough();
    test_reset_mid_resp();
    test_wrap();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
